// File: rtl/slv_spram_if.sv
// Single-port RAM access bus: address/strobe/data in, read result and status out.
interface slv_spram_if #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_WSTRBW = AXI_DW/8
);
    logic [AXI_AW-1:0]     RAM_A;
    logic                  RAM_CEN;
    logic [AXI_DW-1:0]     RAM_D;
    logic [AXI_WSTRBW-1:0] RAM_WEN;
    logic [AXI_DW-1:0]     RAM_Q;
    logic                  RAM_QV;
    logic                  RAM_ERR;
    logic [15:0]           RAM_RCNT;
    logic [15:0]           RAM_WCNT;

    modport master (
        output RAM_A, RAM_CEN, RAM_D, RAM_WEN,
        input  RAM_Q, RAM_QV, RAM_ERR, RAM_RCNT, RAM_WCNT
    );

    modport slave (
        input  RAM_A, RAM_CEN, RAM_D, RAM_WEN,
        output RAM_Q, RAM_QV, RAM_ERR, RAM_RCNT, RAM_WCNT
    );
endinterface

// File: rtl/slv_spram.sv
// Byte-strobed single-port RAM with SLV_WS-cycle read pipeline, sticky range error and access counters.
// Read latency SLV_WS cycles; no backpressure, one access accepted every cycle.
module slv_spram #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_WSTRBW = AXI_DW/8,
    parameter int SLV_WS     = 1,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic       RAM_CLK,
    input  logic       RAM_RESETn,
    slv_spram_if.slave bus
);
    localparam int LSB  = $clog2(AXI_WSTRBW);
    localparam int IDXW = AXI_AW - LSB;
    localparam int MAW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDXW-1:0] DEPTH_IDX = IDXW'(MEM_DEPTH);

    logic [AXI_DW-1:0] mem [MEM_DEPTH];

    logic [IDXW-1:0]   idx;
    logic [MAW-1:0]    widx;
    logic              in_range;
    logic              acc;
    logic              rd;
    logic              wr;
    logic [AXI_DW-1:0] rd_dat;

    logic [SLV_WS-1:0] pv;
    logic [SLV_WS-1:0] nv;
    logic [AXI_DW-1:0] pd [SLV_WS];
    logic [AXI_DW-1:0] nd [SLV_WS];

    logic              err;
    logic [15:0]       rcnt;
    logic [15:0]       wcnt;

    assign idx      = bus.RAM_A[AXI_AW-1:LSB];
    assign widx     = idx[MAW-1:0];
    assign in_range = (idx < DEPTH_IDX);
    assign acc      = ~bus.RAM_CEN;
    assign rd       = acc &  (&bus.RAM_WEN);
    assign wr       = acc & ~(&bus.RAM_WEN);
    assign rd_dat   = (rd && in_range) ? mem[widx] : '0;

    generate
        if (LSB > 0) begin : g_lo
            logic unused_lo;
            assign unused_lo = ^bus.RAM_A[LSB-1:0];
        end
    endgenerate

    // Array has no reset so contents survive RAM_RESETn.
    always_ff @(posedge RAM_CLK) begin
        if (wr && in_range) begin
            for (int i = 0; i < AXI_WSTRBW; i++) begin
                if (!bus.RAM_WEN[i]) begin
                    mem[widx][8*i +: 8] <= bus.RAM_D[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        nv    = '0;
        nv[0] = rd;
        for (int i = 0; i < SLV_WS; i++) begin
            nd[i] = '0;
        end
        nd[0] = rd_dat;
        for (int i = 1; i < SLV_WS; i++) begin
            nv[i] = pv[i-1];
            nd[i] = pd[i-1];
        end
    end

    // The last stage doubles as the output register and holds between results.
    always_ff @(posedge RAM_CLK or negedge RAM_RESETn) begin
        if (!RAM_RESETn) begin
            pv <= '0;
            for (int i = 0; i < SLV_WS; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv <= nv;
            for (int i = 0; i < SLV_WS; i++) begin
                if (i == SLV_WS-1) begin
                    if (nv[i]) begin
                        pd[i] <= nd[i];
                    end
                end else begin
                    pd[i] <= nd[i];
                end
            end
        end
    end

    always_ff @(posedge RAM_CLK or negedge RAM_RESETn) begin
        if (!RAM_RESETn) begin
            err  <= 1'b0;
            rcnt <= '0;
            wcnt <= '0;
        end else begin
            if (acc && !in_range) begin
                err <= 1'b1;
            end
            if (rd && rcnt != 16'hFFFF) begin
                rcnt <= rcnt + 16'd1;
            end
            if (wr && wcnt != 16'hFFFF) begin
                wcnt <= wcnt + 16'd1;
            end
        end
    end

    assign bus.RAM_Q    = pd[SLV_WS-1];
    assign bus.RAM_QV   = pv[SLV_WS-1];
    assign bus.RAM_ERR  = err;
    assign bus.RAM_RCNT = rcnt;
    assign bus.RAM_WCNT = wcnt;
endmodule
